// File: rtl/chirp_gen_pkg.sv
// Shared definitions for the chirp phase generator: chirp type encodings
// and the controller state encoding.
package chirp_gen_pkg;

  localparam int CHIRP_TYPE_SIZE = 2;

  localparam logic [CHIRP_TYPE_SIZE-1:0] TYPE_UP    = 2'd0;
  localparam logic [CHIRP_TYPE_SIZE-1:0] TYPE_DOWN  = 2'd1;
  localparam logic [CHIRP_TYPE_SIZE-1:0] TYPE_QDOWN = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/chirp_freq_step.sv
// Next instantiated frequency of a chirp: one step of phase_inc in the chirp
// direction, folded back into the band [-bw/2, +bw/2) by one bw_sr.
module chirp_freq_step #(
  parameter int PRECISION = 32
) (
  input  logic [PRECISION-1:0] freq,
  input  logic [PRECISION-1:0] phase_inc,
  input  logic [PRECISION-1:0] bw_sr,
  input  logic                 up,
  output logic [PRECISION-1:0] next_freq
);

  logic [PRECISION-1:0] half;
  logic [PRECISION-1:0] neg_half;
  logic [PRECISION-1:0] stepped;

  // Step the frequency and wrap it when it leaves the band edge in the step direction
  always_comb begin
    half      = bw_sr >> 1;
    neg_half  = '0 - half;
    stepped   = '0;
    next_freq = freq;
    if (up) begin
      stepped = freq + phase_inc;
      if ($signed(stepped) >= $signed(half)) next_freq = stepped - bw_sr;
      else                                   next_freq = stepped;
    end else begin
      stepped = freq - phase_inc;
      if ($signed(stepped) < $signed(neg_half)) next_freq = stepped + bw_sr;
      else                                      next_freq = stepped;
    end
  end

endmodule

// File: rtl/chirp_gen.sv
// Per-symbol chirp phase generator. Captures one symbol request, seeds the
// instantaneous frequency, then emits one phase sample per accepted beat.
// The phase accumulator runs continuously across symbols.
module chirp_gen
  import chirp_gen_pkg::*;
#(
  parameter int PRECISION = 32,
  parameter int SYM_W     = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sym_valid,
  output logic                       sym_ready,
  input  logic [SYM_W-1:0]           sym_value,
  input  logic [CHIRP_TYPE_SIZE-1:0] chirp_type,
  input  logic [3:0]                 sf,
  input  logic [PRECISION-1:0]       bw_sr,
  input  logic [PRECISION-1:0]       phase_inc,
  input  logic [PRECISION-1:0]       symbol_size,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PRECISION-1:0]       phase_out,
  output logic [PRECISION-1:0]       freq_out,
  output logic                       sym_done
);

  state_t                     state;
  logic [SYM_W-1:0]           sym_r;
  logic [CHIRP_TYPE_SIZE-1:0] type_r;
  logic [3:0]                 sf_r;
  logic [PRECISION-1:0]       bw_r;
  logic [PRECISION-1:0]       inc_r;
  logic [PRECISION-1:0]       size_r;
  logic [PRECISION-1:0]       counter;

  logic                       is_up;
  logic [PRECISION-1:0]       half;
  logic [PRECISION-1:0]       sym_ext;
  logic [PRECISION-1:0]       offset;
  logic [PRECISION-1:0]       init_freq;
  logic [PRECISION-1:0]       next_freq;
  logic                       last_beat;

  // Starting frequency of the latched symbol: up-chirps start at the band
  // bottom shifted by m bins, down-chirps one step below the band top
  always_comb begin
    is_up     = (type_r == TYPE_UP);
    half      = bw_r >> 1;
    sym_ext   = {{(PRECISION-SYM_W){1'b0}}, sym_r};
    offset    = sym_ext * (bw_r >> sf_r);
    init_freq = is_up ? (offset - half) : (half - inc_r);
    last_beat = (counter == size_r - PRECISION'(1));
  end

  chirp_freq_step #(
    .PRECISION (PRECISION)
  ) u_freq_step (
    .freq      (freq_out),
    .phase_inc (inc_r),
    .bw_sr     (bw_r),
    .up        (is_up),
    .next_freq (next_freq)
  );

  // Controller: capture a request, seed the frequency, then stream samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      sym_ready <= 1'b1;
      out_valid <= 1'b0;
      sym_done  <= 1'b0;
      phase_out <= '0;
      freq_out  <= '0;
      counter   <= '0;
      sym_r     <= '0;
      type_r    <= TYPE_UP;
      sf_r      <= '0;
      bw_r      <= '0;
      inc_r     <= '0;
      size_r    <= '0;
    end else begin
      sym_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sym_valid && sym_ready) begin
            sym_r     <= sym_value;
            type_r    <= chirp_type;
            sf_r      <= sf;
            bw_r      <= bw_sr;
            inc_r     <= phase_inc;
            size_r    <= symbol_size;
            sym_ready <= 1'b0;
            state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          freq_out <= init_freq;
          counter  <= '0;
          if (size_r == '0) begin
            sym_done  <= 1'b1;
            sym_ready <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            out_valid <= 1'b1;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (out_ready) begin
            phase_out <= phase_out + freq_out;
            freq_out  <= next_freq;
            counter   <= counter + PRECISION'(1);
            if (last_beat) begin
              out_valid <= 1'b0;
              sym_done  <= 1'b1;
              sym_ready <= 1'b1;
              state     <= ST_IDLE;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          sym_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chirp_gen.sv
// Self-checking bench for chirp_gen. The reference model computes each
// sample's frequency in closed form (start offset plus k steps, folded into
// the band by modulo) and the phase as a running sum across symbols.
module tb_chirp_gen;
  import chirp_gen_pkg::*;

  localparam int P  = 32;
  localparam int SW = 12;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       sym_valid;
  logic                       sym_ready;
  logic [SW-1:0]              sym_value;
  logic [CHIRP_TYPE_SIZE-1:0] chirp_type;
  logic [3:0]                 sf;
  logic [P-1:0]               bw_sr;
  logic [P-1:0]               phase_inc;
  logic [P-1:0]               symbol_size;
  logic                       out_valid;
  logic                       out_ready;
  logic [P-1:0]               phase_out;
  logic [P-1:0]               freq_out;
  logic                       sym_done;

  int           tests_run    = 0;
  int           tests_failed = 0;
  logic [P-1:0] model_phase  = '0;

  chirp_gen #(.PRECISION(P), .SYM_W(SW)) dut (
    .clk         (clk),
    .rst         (rst),
    .sym_valid   (sym_valid),
    .sym_ready   (sym_ready),
    .sym_value   (sym_value),
    .chirp_type  (chirp_type),
    .sf          (sf),
    .bw_sr       (bw_sr),
    .phase_inc   (phase_inc),
    .symbol_size (symbol_size),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .phase_out   (phase_out),
    .freq_out    (freq_out),
    .sym_done    (sym_done)
  );

  always #5 clk = ~clk;

  // Frequency of sample k: start value moved k steps, folded into a bw-wide band
  function automatic longint exp_freq(input logic [1:0] ct, input longint bw, input int sfv,
                                      input longint m, input longint inc, input longint k);
    longint half, lo, x, r;
    half = bw / 2;
    if (ct == TYPE_UP) begin
      lo = half - bw;
      x  = -half + m * (bw >> sfv) + k * inc;
    end else begin
      lo = -half;
      x  = half - inc - k * inc;
    end
    r = (x - lo) % bw;
    if (r < 0) r = r + bw;
    return lo + r;
  endfunction

  // Issue one symbol at the current negedge and follow it to completion
  task automatic run_symbol(input logic [1:0] ct, input int m, input int sfv, input int bw,
                            input int inc, input int size, input int ready_pct, input int abort_at,
                            output longint first_f, output longint last_f);
    int     k;
    int     cycles;
    longint ef;
    logic   accepted;
    logic [P-1:0] ef_bits;
    first_f = 0;
    last_f  = 0;
    tests_run++;
    if (sym_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL sym_ready_idle: got %b want 1", sym_ready);
    end
    sym_valid   = 1'b1;
    sym_value   = SW'(m);
    chirp_type  = ct;
    sf          = 4'(sfv);
    bw_sr       = P'(bw);
    phase_inc   = P'(inc);
    symbol_size = P'(size);
    @(posedge clk);
    @(negedge clk);
    sym_valid   = 1'b0;
    sym_value   = SW'($urandom);
    chirp_type  = 2'($urandom);
    sf          = 4'($urandom);
    bw_sr       = $urandom;
    phase_inc   = $urandom;
    symbol_size = $urandom;
    tests_run++;
    if ({out_valid, sym_ready, sym_done} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL load_cycle {valid,ready,done}: got %b want 000", {out_valid, sym_ready, sym_done});
    end
    @(negedge clk);
    if (size == 0) begin
      tests_run++;
      if ({out_valid, sym_ready, sym_done} !== 3'b011) begin
        tests_failed++;
        $display("[TB] FAIL zero_size_done {valid,ready,done}: got %b want 011", {out_valid, sym_ready, sym_done});
      end
      return;
    end
    k = 0;
    cycles = 0;
    while (k < size && cycles < size * 20 + 100) begin
      if (abort_at == k) begin
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({out_valid, sym_ready, sym_done, phase_out, freq_out} !== {3'b010, {P{1'b0}}, {P{1'b0}}}) begin
          tests_failed++;
          $display("[TB] FAIL async_reset: got valid=%b ready=%b done=%b phase=%0h freq=%0h want 0 1 0 0 0",
                   out_valid, sym_ready, sym_done, phase_out, freq_out);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          tests_run++;
          if (sym_done !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_no_done: got done=%b valid=%b want 0 0", sym_done, out_valid);
          end
        end
        rst = 1'b0;
        model_phase = '0;
        @(negedge clk);
        return;
      end
      ef      = exp_freq(ct, longint'(bw), sfv, longint'(m), longint'(inc), longint'(k));
      ef_bits = ef[P-1:0];
      tests_run++;
      if ({out_valid, sym_ready, sym_done} !== 3'b100 || freq_out !== ef_bits || phase_out !== model_phase) begin
        tests_failed++;
        $display("[TB] FAIL sample %0d: got valid=%b ready=%b done=%b freq=%0d phase=%0h want 1 0 0 freq=%0d phase=%0h",
                 k, out_valid, sym_ready, sym_done, $signed(freq_out), phase_out, ef, model_phase);
      end
      if (k == 0) first_f = longint'($signed(freq_out));
      last_f = longint'($signed(freq_out));
      out_ready = ($urandom_range(99) < ready_pct);
      @(posedge clk);
      accepted = out_ready;
      @(negedge clk);
      if (accepted) begin
        model_phase = model_phase + ef_bits;
        k++;
      end
      cycles++;
    end
    tests_run++;
    if (k < size) begin
      tests_failed++;
      $display("[TB] FAIL sample_budget: got %0d samples want %0d", k, size);
      return;
    end
    tests_run++;
    if ({out_valid, sym_ready, sym_done} !== 3'b011 || phase_out !== model_phase) begin
      tests_failed++;
      $display("[TB] FAIL sym_done_pulse: got valid=%b ready=%b done=%b phase=%0h want 0 1 1 phase=%0h",
               out_valid, sym_ready, sym_done, phase_out, model_phase);
    end
  endtask

  task automatic check_ends(input string name, input longint ff, input longint lf,
                            input longint want_first, input longint want_last);
    tests_run++;
    if (ff != want_first || lf != want_last) begin
      tests_failed++;
      $display("[TB] FAIL %s endpoints: got first=%0d last=%0d want first=%0d last=%0d",
               name, ff, lf, want_first, want_last);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({out_valid, sym_ready, sym_done, phase_out, freq_out} !== {3'b010, {P{1'b0}}, {P{1'b0}}}) begin
      tests_failed++;
      $display("[TB] FAIL reset_values: got valid=%b ready=%b done=%b phase=%0h freq=%0h want 0 1 0 0 0",
               out_valid, sym_ready, sym_done, phase_out, freq_out);
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({out_valid, sym_ready, sym_done} !== 3'b010) begin
      tests_failed++;
      $display("[TB] FAIL idle_after_reset: got %b want 010", {out_valid, sym_ready, sym_done});
    end
  endtask

  task automatic test_up_chirp();
    longint ff, lf;
    run_symbol(TYPE_UP, 0, 7, 1024, 8, 128, 100, -1, ff, lf);
    check_ends("up_m0", ff, lf, -512, 504);
    run_symbol(TYPE_UP, 64, 7, 1024, 8, 128, 100, -1, ff, lf);
    check_ends("up_m64", ff, lf, 0, -8);
  endtask

  task automatic test_down_chirps();
    longint ff, lf;
    run_symbol(TYPE_DOWN, 99, 7, 1024, 8, 128, 100, -1, ff, lf);
    check_ends("down", ff, lf, 504, -512);
    run_symbol(TYPE_QDOWN, 5, 7, 1024, 8, 32, 100, -1, ff, lf);
    check_ends("quarter_down", ff, lf, 504, 256);
  endtask

  task automatic test_stall();
    longint ff, lf;
    run_symbol(TYPE_UP, 0, 7, 1024, 8, 128, 50, -1, ff, lf);
    check_ends("stalled_up", ff, lf, -512, 504);
  endtask

  task automatic test_reset_mid_symbol();
    longint ff, lf;
    run_symbol(TYPE_UP, 0, 7, 1024, 8, 128, 100, 40, ff, lf);
    run_symbol(TYPE_UP, 3, 7, 1024, 8, 0, 100, -1, ff, lf);
  endtask

  task automatic test_back_to_back();
    longint ff, lf;
    int sfv, bw, m, inc, size;
    logic [1:0] ct;
    for (int i = 0; i < 10; i++) begin
      sfv  = $urandom_range(12, 6);
      bw   = 2 * $urandom_range(1 << 20, 32);
      m    = $urandom_range((1 << sfv) - 1, 0);
      inc  = $urandom_range(bw - 1, 1);
      size = $urandom_range(40, 1);
      ct   = 2'($urandom_range(2, 0));
      run_symbol(ct, m, sfv, bw, inc, size, 70, -1, ff, lf);
    end
  endtask

  initial begin
    rst         = 1'b1;
    sym_valid   = 1'b0;
    sym_value   = '0;
    chirp_type  = TYPE_UP;
    sf          = 4'd7;
    bw_sr       = '0;
    phase_inc   = '0;
    symbol_size = '0;
    out_ready   = 1'b1;
    test_reset();
    test_up_chirp();
    test_down_chirps();
    test_stall();
    test_reset_mid_symbol();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
